// File: rtl/counter_pkg.sv
// Shared mode encoding for the parametrised counter family.
package counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP   = 2'b00;
    localparam mode_t MODE_DN1  = 2'b01;
    localparam mode_t MODE_DNB  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the counter: new value, wrap (carry/borrow) and load flag.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP_BIG = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_t            mode_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             wrap_o,
    output logic             load_o
);

    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP_BIG);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] arith;

    assign q_ext = {1'b0, q_i};

    // Bit WIDTH of the widened result is the carry (up) or borrow (down).
    always_comb begin
        arith  = q_ext;
        load_o = 1'b0;
        case (mode_i)
            MODE_UP:   arith = q_ext + ONE_EXT;
            MODE_DN1:  arith = q_ext - ONE_EXT;
            MODE_DNB:  arith = q_ext - STEP_EXT;
            default: begin
                arith  = {1'b0, d_i};
                load_o = 1'b1;
            end
        endcase
    end

    assign q_next_o = arith[WIDTH-1:0];
    assign wrap_o   = arith[WIDTH];

endmodule

// File: rtl/counter_param.sv
// Parametrised up/down/load counter with registered rco for cascading and a load pulse.
module counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP_BIG = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             load_nxt;

    counter_next #(
        .WIDTH    (WIDTH),
        .STEP_BIG (STEP_BIG)
    ) u_next (
        .q_i      (q_q),
        .mode_i   (mode),
        .d_i      (D),
        .q_next_o (q_nxt),
        .wrap_o   (wrap_nxt),
        .load_o   (load_nxt)
    );

    // Disabled cycles hold the count and drop both pulses.
    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (enable) begin
            q_d    = q_nxt;
            rco_d  = wrap_nxt;
            load_d = load_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
        end
    end

    assign Q    = q_q;
    assign rco  = rco_q;
    assign load = load_q;

endmodule
